// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Optional abort-on-timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Round-robin pick: data wins only if alone or fetch was served last.
    function automatic logic pick_data(input logic f, input logic d,
                                       input logic last);
        return d & (~f | (last == OWN_FETCH));
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-cycle watchdog for the memory arbiter.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of BUSY cycles already completed
    assign expired = busy & (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without MOC.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic        memEnable,
    output logic        RW,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    input  logic        MOC,
    output logic        owner,
    output logic        timeout_err
);

    import mem_arb_pkg::*;

    arb_state_e  state_d, state_q;
    logic        mem_en_d, mem_en_q;
    logic        rw_d, rw_q;
    logic        byte_d, byte_q;
    logic [31:0] addr_d, addr_q;
    logic        owner_d, owner_q;
    logic        last_d, last_q;
    logic        f_ack_d, f_ack_q;
    logic        d_ack_d, d_ack_q;
    logic        terr_d, terr_q;
    logic        grant;
    logic        start;
    logic        timeout;

    always_comb begin
        state_d  = state_q;
        mem_en_d = mem_en_q;
        rw_d     = rw_q;
        byte_d   = byte_q;
        addr_d   = addr_q;
        owner_d  = owner_q;
        last_d   = last_q;
        f_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        terr_d   = 1'b0;
        grant    = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                if (f_req | d_req) begin
                    grant    = pick_data(f_req, d_req, last_q);
                    start    = 1'b1;
                    state_d  = BUSY;
                    mem_en_d = 1'b1;
                    owner_d  = grant;
                    addr_d   = grant ? d_addr : f_addr;
                    rw_d     = grant & d_rw;
                    byte_d   = grant & d_byte;
                end
            end
            BUSY: begin
                // MOC takes priority over a coincident timeout
                if (MOC | timeout) begin
                    state_d  = ACK;
                    mem_en_d = 1'b0;
                    f_ack_d  = (owner_q == OWN_FETCH);
                    d_ack_d  = (owner_q == OWN_DATA);
                    terr_d   = ~MOC;
                end
            end
            ACK: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                last_d   = owner_q;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            rw_q     <= 1'b0;
            byte_q   <= 1'b0;
            addr_q   <= '0;
            owner_q  <= OWN_FETCH;
            last_q   <= OWN_DATA;
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            rw_q     <= rw_d;
            byte_q   <= byte_d;
            addr_q   <= addr_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            f_ack_q  <= f_ack_d;
            d_ack_q  <= d_ack_d;
            terr_q   <= terr_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .busy   (state_q == BUSY),
        .expired(timeout)
    );
    assign timeout_err = terr_q;
`else
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign memEnable = mem_en_q;
    assign RW        = rw_q;
    assign mem_byte  = byte_q;
    assign mem_addr  = addr_q;
    assign owner     = owner_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; timeout case runs with MEM_ARB_TIMEOUT_EN.
// Directed transactions push expectations; a negedge monitor checks each ack.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic        d_req;
    logic        d_rw;
    logic        d_byte;
    logic [31:0] d_addr;
    logic        d_ack;
    logic        memEnable;
    logic        RW;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic        MOC;
    logic        owner;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int moc_lat = -1;
    bit force_moc = 0;
    int busy_cnt = 0;

    typedef struct {
        bit          own;
        logic [31:0] addr;
        bit          rw;
        bit          byt;
        bit          terr;
        int          en;
    } exp_t;

    exp_t q[$];

    mem_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_ack      (f_ack),
        .d_req      (d_req),
        .d_rw       (d_rw),
        .d_byte     (d_byte),
        .d_addr     (d_addr),
        .d_ack      (d_ack),
        .memEnable  (memEnable),
        .RW         (RW),
        .mem_byte   (mem_byte),
        .mem_addr   (mem_addr),
        .MOC        (MOC),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit own, input logic [31:0] a, input bit rw,
                        input bit b, input bit t, input int en);
        exp_t e;
        e = '{own, a, rw, b, t, en};
        q.push_back(e);
    endtask

    // Memory model: MOC in the (moc_lat+1)-th cycle of memEnable
    initial begin
        MOC = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (memEnable) busy_cnt++;
            else busy_cnt = 0;
            MOC = force_moc ||
                  (moc_lat >= 0 && memEnable && busy_cnt == moc_lat + 1);
        end
    end

    // Monitor
    initial begin
        bit          prev_en = 0;
        bit          stable = 1;
        int          en_cnt = 0;
        logic [31:0] cap_addr = '0;
        bit          cap_rw = 0;
        bit          cap_byte = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 0;
                en_cnt = 0;
            end else begin
                if (memEnable && !prev_en) begin
                    cap_addr = mem_addr;
                    cap_rw   = RW;
                    cap_byte = mem_byte;
                    stable   = 1;
                    en_cnt   = 1;
                end else if (memEnable) begin
                    en_cnt++;
                    if (mem_addr !== cap_addr || RW !== cap_rw ||
                        mem_byte !== cap_byte) stable = 0;
                end
                if (f_ack || d_ack) begin
                    chk("ack_excl", 32'(f_ack & d_ack), 0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: f_ack=%0b d_ack=%0b expected none",
                                 f_ack, d_ack);
                    end else begin
                        e = q.pop_front();
                        chk("ack_owner", 32'(owner), 32'(e.own));
                        chk("ack_kind", 32'(e.own ? d_ack : f_ack), 1);
                        chk("addr", cap_addr, e.addr);
                        chk("rw", 32'(cap_rw), 32'(e.rw));
                        chk("byte", 32'(cap_byte), 32'(e.byt));
                        chk("timeout_err", 32'(timeout_err), 32'(e.terr));
                        chk("en_cycles", 32'(en_cnt), 32'(e.en));
                        chk("addr_stable", 32'(stable), 1);
                    end
                end
                prev_en = memEnable;
            end
        end
    end

    task automatic fetch_txn(input logic [31:0] a, input int n);
        int got = 0;
        f_addr = a;
        f_req  = 1'b1;
        for (int c = 0; c < 100 && got < n; c++) begin
            @(posedge clk);
            #1;
            if (f_ack) begin
                got++;
                f_addr = f_addr + 32'd4;
            end
        end
        f_req = 1'b0;
        chk("fetch_wait", 32'(got), 32'(n));
    endtask

    task automatic data_txn(input logic [31:0] a, input bit rw, input bit b,
                            input int n);
        int got = 0;
        d_addr = a;
        d_rw   = rw;
        d_byte = b;
        d_req  = 1'b1;
        for (int c = 0; c < 100 && got < n; c++) begin
            @(posedge clk);
            #1;
            if (d_ack) begin
                got++;
                d_addr = d_addr + 32'd4;
            end
        end
        d_req = 1'b0;
        chk("data_wait", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        f_req  = 1'b0;
        f_addr = '0;
        d_req  = 1'b0;
        d_rw   = 1'b0;
        d_byte = 1'b0;
        d_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_en", 32'(memEnable), 0);
        chk("rst_rw", 32'(RW), 0);
        chk("rst_byte", 32'(mem_byte), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_f_ack", 32'(f_ack), 0);
        chk("rst_d_ack", 32'(d_ack), 0);
        chk("rst_terr", 32'(timeout_err), 0);

        // Single fetch, MOC in 4th busy cycle
        @(posedge clk);
        #1;
        moc_lat = 3;
        push(0, 32'h10, 0, 0, 0, 4);
        fetch_txn(32'h10, 1);
        repeat (2) @(posedge clk);

        // Simultaneous requests right after reset: fetch first
        do_reset();
        moc_lat = 1;
        push(0, 32'h20, 0, 0, 0, 2);
        push(1, 32'h40, 1, 1, 0, 2);
        fork
            fetch_txn(32'h20, 1);
            data_txn(32'h40, 1, 1, 1);
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("owner_hold", 32'(owner), 1);

        // Continuous requests alternate
        @(posedge clk);
        #1;
        push(0, 32'h100, 0, 0, 0, 2);
        push(1, 32'h200, 0, 0, 0, 2);
        push(0, 32'h104, 0, 0, 0, 2);
        push(1, 32'h204, 0, 0, 0, 2);
        fork
            fetch_txn(32'h100, 2);
            data_txn(32'h200, 0, 0, 2);
        join

        // MOC while idle is ignored
        repeat (2) @(posedge clk);
        #1;
        force_moc = 1;
        @(posedge clk);
        #1;
        force_moc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("moc_idle_en", 32'(memEnable), 0);
        chk("moc_idle_owner", 32'(owner), 1);

        // Reset in second busy cycle of a data write
        @(posedge clk);
        #1;
        moc_lat = -1;
        d_addr = 32'h300;
        d_rw   = 1'b1;
        d_byte = 1'b0;
        d_req  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (memEnable) break;
        end
        chk("abort_start", 32'(memEnable), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_en", 32'(memEnable), 0);
        chk("abort_d_ack", 32'(d_ack), 0);
        reset = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        moc_lat = 1;
        push(0, 32'h400, 0, 0, 0, 2);
        push(1, 32'h500, 0, 0, 0, 2);
        fork
            fetch_txn(32'h400, 1);
            data_txn(32'h500, 0, 0, 1);
        join

`ifdef MEM_ARB_TIMEOUT_EN
        // No MOC: abort after 4 busy cycles
        repeat (2) @(posedge clk);
        #1;
        moc_lat = -1;
        push(1, 32'h600, 1, 0, 1, 4);
        data_txn(32'h600, 1, 0, 1);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
